led_sweep_ctrl: RTL and testbench
=================================

# led_sweep_ctrl

Sequencer for the 8-LED sweep datapath: owns step timing, pattern mode and run/stop control of the LED shift register, replacing free-running operation with start/stop-driven sequencing. Sits between the board's button/switch decode logic and the LED pins. Provides a per-sweep completion pulse for downstream counters.

## Interface
- `BASE`, 16: base prescale in clock cycles, must be ≥1. Step period = `BASE*(speed+1)` cycles.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `start` input 1: level, sampled each cycle; begins a run from IDLE.
- `stop` input 1: level, sampled each cycle; ends a run.
- `mode` input 2: 0 bounce, 1 rotate-right, 2 rotate-left, 3 blink; sampled only on an accepted start.
- `speed` input 4: step-period multiplier; sampled only on an accepted start.
- `dataOut` output 8: LED pattern, registered.
- `busy` output 1: high while in RUN, registered.
- `sweep_done` output 1: one-cycle pulse on each pattern-cycle completion, registered.

## Operation
- Reset (rst=0, asynchronous): state IDLE, `dataOut`=8'h00, `busy`=0, `sweep_done`=0, dir=right, prescaler and step counters=0, latched mode=0, latched speed=0.
- States:
  - IDLE → RUN on start=1 and stop=0.
  - RUN → IDLE on stop=1.
  - No other transitions.
- Accepted start:
  - Latch mode and speed.
  - Clear both counters.
  - Set dir=right and `busy`=1.
  - Load seed: 8'h80 for modes 0 and 1, 8'h01 for mode 2, 8'hAA for mode 3.
- start while in RUN is ignored; the latched mode and speed are unchanged.
- Simultaneous start and stop: stop wins. In IDLE nothing happens; in RUN the block goes to IDLE.
- Stop:
  - Next edge: `dataOut`=8'h00, `busy`=0, `sweep_done`=0.
  - Counters cleared; a pending step is discarded.
- Step generation:
  - Prescaler counts 0..BASE-1.
  - On wrap, the step counter counts 0..speed.
  - A step fires when both counters are at their terminal values; both then return to 0.
- Step actions by latched mode:
  - Mode 0 (bounce): dir=right gives `dataOut`>>1; dir=left gives `dataOut`<<1. The step producing 8'h01 sets dir=left; the step producing 8'h80 sets dir=right.
  - Mode 1: rotate right, {d[0],d[7:1]}.
  - Mode 2: rotate left, {d[6:0],d[7]}.
  - Mode 3: `dataOut` = ~`dataOut`.
- `sweep_done` pulses high in the same cycle `dataOut` takes the value below, and is 0 otherwise:
  - Mode 0: 8'h01 or 8'h80.
  - Modes 1 and 2: the seed value.
  - Mode 3: 8'hAA.
- Counter width: 22 bits for the prescaler, 4 bits for the step counter; no overflow is possible for BASE ≤ 2^22.

## Timing
- start sampled high at edge N (IDLE): seed and `busy`=1 visible after edge N.
- First step at edge N + BASE*(speed+1); each subsequent step every BASE*(speed+1) cycles.
- stop sampled at edge M: IDLE outputs visible after edge M. A step scheduled for edge M does not occur.
- Reset asserted mid-run takes effect immediately (asynchronous). After release, the block is in IDLE and waits for start.
- `sweep_done` latency: zero relative to the corresponding `dataOut` update.

## Configuration
- `LEDSWEEP_DWELL_EN` defined: in mode 0, the step after reaching 8'h01 or 8'h80 holds `dataOut` unchanged for one extra step period, then reverses. `sweep_done` pulses only on arrival, not on the hold step.
  - Example sequence: …02, 01, 01, 02…
- `LEDSWEEP_DWELL_EN` undefined: reversal is immediate.
  - Example sequence: …02, 01, 02…
- Other modes are unaffected in both builds.

## Test plan
- Reset: rst=0 mid-run → `dataOut`=00, `busy`=0, `sweep_done`=0 immediately, with no clock edge required. After release, no activity until start.
- Bounce timing (BASE=4, speed=1, mode 0, start at edge N):
  - Step period is 8 cycles.
  - 80 after N; 40 at N+8; … 01 at N+56 with `sweep_done`=1 for one cycle.
  - 02 at N+64 (no dwell build); 01 at N+64 and 02 at N+72 (dwell build).
- Rotate-left wrap (BASE=1, speed=0, mode 2): output 01,02,…,80,01. `sweep_done` pulses exactly when 01 reappears, 8 cycles after start.
- Blink (BASE=2, speed=0, mode 3): AA, 55, AA every 2 cycles. `sweep_done` pulses on each return to AA.
- Stop mid-run: stop coincident with a scheduled step → `dataOut`=00, `busy`=0, and no shifted value is ever visible. start and stop high together in IDLE → remains IDLE.
- Mode/speed change while running: change mode to 3 and speed to 0 during a mode 1, speed 2 run → rotation and the 3×BASE period continue unchanged until stop and a new start.

Source files
------------

// File: rtl/led_sweep_ctrl.sv
// led_sweep_ctrl: start/stop sequencer for the 8-LED sweep.
// It owns the step timing (prescaler plus step counter), the pattern mode and
// the run/stop control of the LED pattern register. It also raises a
// one-cycle completion pulse each time a pattern cycle finishes.
// Optional feature macro: LEDSWEEP_DWELL_EN. When it is defined, bounce mode
// holds the end LED for one extra step period before it reverses.

module led_sweep_ctrl #(
   parameter int unsigned BASE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic [1:0] mode,
   input  logic [3:0] speed,
   output logic [7:0] dataOut,
   output logic       busy,
   output logic       sweep_done
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef enum logic [1:0] {
      MODE_BOUNCE = 2'd0,
      MODE_ROR    = 2'd1,
      MODE_ROL    = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_t;

`ifdef LEDSWEEP_DWELL_EN
   localparam bit DWELL_EN = 1'b1;
`else
   localparam bit DWELL_EN = 1'b0;
`endif

   // The prescaler wraps at BASE-1, so a BASE of 1 gives a step on every
   // wrap of the step counter.
   localparam logic [21:0] PRESC_LAST = 22'(BASE - 1);

   state_t      state;
   mode_t       mode_q;
   logic [3:0]  speed_q;
   dir_t        dir;
   logic [21:0] presc;
   logic [3:0]  step_cnt;
   logic        hold;

   logic        presc_wrap;
   logic        step_fire;
   logic [7:0]  nxt_data;
   dir_t        nxt_dir;
   logic        nxt_done;
   logic        nxt_hold;

   // Returns the first pattern shown after a run is accepted.
   function automatic logic [7:0] seed_for(input logic [1:0] m);
      logic [7:0] s;
      case (m)
         2'd0:    s = 8'h80;
         2'd1:    s = 8'h80;
         2'd2:    s = 8'h01;
         default: s = 8'hAA;
      endcase
      return s;
   endfunction

   // A step fires only when both counters are at their terminal values.
   always_comb begin
      presc_wrap = (presc == PRESC_LAST);
      step_fire  = (state == RUN) && presc_wrap && (step_cnt == speed_q);
   end

   // Computes the pattern, direction and completion flag for the next step
   // of the latched mode.
   always_comb begin
      nxt_data = dataOut;
      nxt_dir  = dir;
      nxt_done = 1'b0;
      nxt_hold = 1'b0;
      case (mode_q)
         MODE_BOUNCE: begin
            if (DWELL_EN && hold) begin
               // The end LED stays lit for this step. The direction was
               // already flipped on arrival, so the next step moves back.
               nxt_data = dataOut;
               nxt_hold = 1'b0;
            end else begin
               if (dir == DIR_RIGHT) begin
                  nxt_data = dataOut >> 1;
               end else begin
                  nxt_data = dataOut << 1;
               end
               if (nxt_data == 8'h01) begin
                  nxt_dir  = DIR_LEFT;
                  nxt_done = 1'b1;
                  nxt_hold = DWELL_EN;
               end else if (nxt_data == 8'h80) begin
                  nxt_dir  = DIR_RIGHT;
                  nxt_done = 1'b1;
                  nxt_hold = DWELL_EN;
               end
            end
         end
         MODE_ROR: begin
            nxt_data = {dataOut[0], dataOut[7:1]};
            nxt_done = (nxt_data == 8'h80);
         end
         MODE_ROL: begin
            nxt_data = {dataOut[6:0], dataOut[7]};
            nxt_done = (nxt_data == 8'h01);
         end
         MODE_BLINK: begin
            nxt_data = ~dataOut;
            nxt_done = (nxt_data == 8'hAA);
         end
         default: begin
            nxt_data = dataOut;
         end
      endcase
   end

   // Run/stop state machine together with its counters and registered
   // outputs. In RUN, stop is checked first, so a step due on the same edge
   // is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         mode_q     <= MODE_BOUNCE;
         speed_q    <= 4'd0;
         dir        <= DIR_RIGHT;
         presc      <= 22'd0;
         step_cnt   <= 4'd0;
         hold       <= 1'b0;
         dataOut    <= 8'h00;
         busy       <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         sweep_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state    <= RUN;
                  mode_q   <= mode_t'(mode);
                  speed_q  <= speed;
                  dir      <= DIR_RIGHT;
                  presc    <= 22'd0;
                  step_cnt <= 4'd0;
                  hold     <= 1'b0;
                  busy     <= 1'b1;
                  dataOut  <= seed_for(mode);
               end
            end
            RUN: begin
               if (stop) begin
                  state    <= IDLE;
                  presc    <= 22'd0;
                  step_cnt <= 4'd0;
                  hold     <= 1'b0;
                  busy     <= 1'b0;
                  dataOut  <= 8'h00;
               end else begin
                  if (presc_wrap) begin
                     presc <= 22'd0;
                     if (step_cnt == speed_q) begin
                        step_cnt <= 4'd0;
                     end else begin
                        step_cnt <= step_cnt + 4'd1;
                     end
                  end else begin
                     presc <= presc + 22'd1;
                  end
                  if (step_fire) begin
                     dataOut    <= nxt_data;
                     dir        <= nxt_dir;
                     hold       <= nxt_hold;
                     sweep_done <= nxt_done;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               dataOut <= 8'h00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// tb_led_sweep_ctrl: scoreboard bench for led_sweep_ctrl.
// The driver applies inputs at each falling edge. It then pushes the
// expected output for the next rising edge. The expected output is computed
// in closed form from the elapsed run time, the step period and the pattern
// rules. The monitor pops and compares just after each rising edge. It also
// checks that the outputs are cleared as soon as reset asserts.

module tb_led_sweep_ctrl;

   localparam int unsigned BASE = 2;

   typedef struct packed {
      logic [7:0] data;
      logic       busy;
      logic       done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [3:0] speed = 4'd0;
   logic [7:0] dataOut;
   logic       busy;
   logic       sweep_done;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];

   bit m_run = 1'b0;
   int m_mode = 0;
   int m_period = 1;
   int m_elapsed = 0;

   led_sweep_ctrl #(.BASE(BASE)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .mode       (mode),
      .speed      (speed),
      .dataOut    (dataOut),
      .busy       (busy),
      .sweep_done (sweep_done)
   );

   // Free-running clock with a 10 time-unit period.
   always #5 clk = ~clk;

   // Returns the lit LED index after k steps of bounce, starting from bit 7.
   function automatic int bounce_bit(input int k);
      int i;
`ifdef LEDSWEEP_DWELL_EN
      i = k % 16;
      if (i <= 7) return 7 - i;
      if (i == 8) return 0;
      return i - 8;
`else
      i = k % 14;
      if (i <= 7) return 7 - i;
      return i - 7;
`endif
   endfunction

   // Returns the pattern shown after k steps of a run in mode m.
   function automatic logic [7:0] model_data(input int m, input int k);
      logic [7:0] one;
      logic [7:0] top;
      one = 8'h01;
      top = 8'h80;
      case (m)
         0:       return one << bounce_bit(k);
         1:       return top >> (k % 8);
         2:       return one << (k % 8);
         default: return ((k % 2) == 0) ? 8'hAA : 8'h55;
      endcase
   endfunction

   // Returns whether step k (k >= 1) of mode m completes a pattern cycle.
   function automatic bit model_done(input int m, input int k);
      case (m)
         0: begin
`ifdef LEDSWEEP_DWELL_EN
            return ((k % 16) == 7) || ((k % 16) == 15);
`else
            return (model_data(0, k) == 8'h01) || (model_data(0, k) == 8'h80);
`endif
         end
         1, 2:    return (k % 8) == 0;
         default: return (k % 2) == 0;
      endcase
   endfunction

   // Drives one cycle of inputs and queues the output expected after the
   // next rising edge.
   task automatic applyStimulus(input bit s, input bit p, input logic [1:0] md, input logic [3:0] sp);
      exp_t e;
      int   k;
      @(negedge clk);
      start = s;
      stop  = p;
      mode  = md;
      speed = sp;
      if (p) begin
         m_run = 1'b0;
      end else if (!m_run && s) begin
         m_run     = 1'b1;
         m_mode    = int'(md);
         m_period  = BASE * (int'(sp) + 1);
         m_elapsed = 0;
      end else if (m_run) begin
         m_elapsed++;
      end
      if (!m_run) begin
         e = '{8'h00, 1'b0, 1'b0};
      end else begin
         k      = m_elapsed / m_period;
         e.data = model_data(m_mode, k);
         e.busy = 1'b1;
         e.done = ((m_elapsed % m_period) == 0) && (k >= 1) && model_done(m_mode, k);
      end
      exp_q.push_back(e);
   endtask

   // Compares the DUT outputs against one expected entry.
   task automatic checkOutput(input string name, input exp_t e);
      checks++;
      if (dataOut !== e.data || busy !== e.busy || sweep_done !== e.done) begin
         errors++;
         $display("[TB] FAIL %s t=%0t: got data=%02h busy=%0b done=%0b, expected data=%02h busy=%0b done=%0b",
                  name, $time, dataOut, busy, sweep_done, e.data, e.busy, e.done);
      end
   endtask

   // Asserts reset between clock edges in the middle of a cycle, holds it
   // for two edges, then releases it.
   task automatic assertReset();
      @(posedge clk);
      #3;
      rst   = 1'b0;
      m_run = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Monitor: while reset is low the outputs must be zero. This includes the
   // instant reset falls, when no clock edge has yet occurred. Otherwise it
   // checks the next scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or negedge rst);
         #1;
         if (!rst) begin
            checkOutput("reset", '{8'h00, 1'b0, 1'b0});
         end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("cycle", e);
         end
      end
   end

   // Stimulus: directed scenarios first, then a randomized stress run.
   initial begin
      bit         s;
      bit         p;
      logic [1:0] md;
      logic [3:0] sp;

      $display("[TB] starting, BASE=%0d", BASE);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // After reset the block stays idle without start.
      repeat (5) applyStimulus(1'b0, 1'b0, 2'd1, 4'd3);

      // With start and stop high together in IDLE, the block stays idle.
      applyStimulus(1'b1, 1'b1, 2'd0, 4'd0);
      repeat (3) applyStimulus(1'b0, 1'b0, 2'd0, 4'd0);

      // Bounce with speed 1, through both reversals.
      applyStimulus(1'b1, 1'b0, 2'd0, 4'd1);
      repeat (80) applyStimulus(1'b0, 1'b0, 2'd0, 4'd1);
      applyStimulus(1'b0, 1'b1, 2'd0, 4'd1);

      // Rotate-left with speed 0, including the wrap back to 01.
      applyStimulus(1'b1, 1'b0, 2'd2, 4'd0);
      repeat (20) applyStimulus(1'b0, 1'b0, 2'd2, 4'd0);
      applyStimulus(1'b0, 1'b1, 2'd2, 4'd0);

      // Start a rotate-right run with speed 2. Then hold start high while
      // mode and speed change; the run must keep its latched settings.
      applyStimulus(1'b1, 1'b0, 2'd1, 4'd2);
      repeat (40) applyStimulus(1'b1, 1'b0, 2'd3, 4'd0);
      // Stop wins over start while running.
      applyStimulus(1'b1, 1'b1, 2'd3, 4'd0);
      // A new start picks up blink with speed 0.
      applyStimulus(1'b1, 1'b0, 2'd3, 4'd0);
      repeat (12) applyStimulus(1'b0, 1'b0, 2'd3, 4'd0);
      applyStimulus(1'b0, 1'b1, 2'd3, 4'd0);

      // Stop on the same edge as a scheduled step.
      applyStimulus(1'b1, 1'b0, 2'd1, 4'd1);
      repeat (5) applyStimulus(1'b0, 1'b0, 2'd1, 4'd1);
      for (int i = 0; i < 64 && ((m_elapsed + 1) % m_period) != 0; i++) begin
         applyStimulus(1'b0, 1'b0, 2'd1, 4'd1);
      end
      applyStimulus(1'b0, 1'b1, 2'd1, 4'd1);
      repeat (4) applyStimulus(1'b0, 1'b0, 2'd1, 4'd1);

      // Assert asynchronous reset mid-run, then confirm the block stays idle.
      applyStimulus(1'b1, 1'b0, 2'd0, 4'd0);
      repeat (9) applyStimulus(1'b0, 1'b0, 2'd0, 4'd0);
      assertReset();
      repeat (6) applyStimulus(1'b0, 1'b0, 2'd2, 4'd2);

      // Randomized stress run.
      for (int n = 0; n < 2500; n++) begin
         s  = ($urandom_range(0, 9) == 0);
         p  = ($urandom_range(0, 69) == 0);
         md = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            sp = 4'($urandom_range(0, 15));
         end else begin
            sp = 4'($urandom_range(0, 3));
         end
         applyStimulus(s, p, md, sp);
      end

      // Let the monitor consume the last queued entries.
      repeat (3) @(posedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
